evt_time_marker: RTL and testbench
==================================

Name: evt_time_marker

Overview:
- Upstream neighbour of the time-gap filler in the streamer path.
- Accepts raw spike events, each tagged with an absolute timestamp, from the sensor/DMA side.
- Produces a serialized event stream in which a time event (op=TIME) precedes the first spike of every new timestamp. The downstream stage then fills gaps and drops repeated times.
- One-entry registered output stage; sustains 1 event/cycle when no marker is needed.

Parameters:
- TIME_W, 16: timestamp width.
- PAYLOAD_W, 16: spike payload width; must satisfy PAYLOAD_W >= TIME_W.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset; asynchronous, active-low
- enable_i  in  1  1 = insert markers; 0 = pass spikes through unmodified
- clear_i  in  1  synchronous pulse: clears err_backwards_o and marker_cnt_o
- in_valid_i  in  1  input event valid
- in_ready_o  out  1  input event accepted when in_valid_i & in_ready_o
- in_time_i  in  TIME_W  absolute timestamp of the input spike
- in_payload_i  in  PAYLOAD_W  spike payload
- out_valid_o  out  1  output event valid
- out_ready_i  in  1  downstream ready
- out_is_time_o  out  1  1 = time event, 0 = spike
- out_data_o  out  PAYLOAD_W  spike payload, or timestamp zero-extended when out_is_time_o=1
- err_backwards_o  out  1  sticky: a non-monotonic timestamp was seen
- marker_cnt_o  out  16  number of time events emitted; saturates at 0xFFFF

Behaviour:
- Reset values: out_valid_o=0, out_is_time_o=0, out_data_o=0, err_backwards_o=0, marker_cnt_o=0. Internal last_time=0, have_time=0, state=IDLE.
- All outputs are registered. No combinational path from in_* to out_*.
- out_ready_i reaches in_ready_o combinationally.
- AXI-style hold: while out_valid_o & ~out_ready_i, out_is_time_o and out_data_o stay stable.
- FSM state IDLE:
  - in_ready_o = ~out_valid_o | out_ready_i.
  - On accept, need_marker = enable_i & (~have_time | in_time_i != last_time).
  - If need_marker: load output with marker (is_time=1, data=in_time_i); store payload in hold register; last_time<=in_time_i; have_time<=1; marker_cnt_o increments (saturating); go to DATA_PEND.
  - Else: load output with spike (is_time=0, data=in_payload_i); stay in IDLE.
  - If nothing is accepted and out_ready_i=1: out_valid_o<=0.
- FSM state DATA_PEND:
  - in_ready_o=0.
  - When out_ready_i=1: load output with the held spike; go to IDLE.
- Latency:
  - Spike without marker: visible 1 cycle after accept.
  - Spike with marker: marker 1 cycle after accept; spike no earlier than 1 cycle after the marker handshake.
- Backwards detection: accept with enable_i & have_time & in_time_i < last_time & in_time_i != 0 -> err_backwards_o<=1.
  - The event is still forwarded with its marker; last_time takes the new value.
  - in_time_i=0 counts as a legal timebase restart and is not flagged.
- enable_i=0:
  - Pure pipeline: no markers; have_time<=0, so the first accepted event after re-enable always gets a marker.
  - An already-pending DATA_PEND spike still completes.
- clear_i: same cycle, err_backwards_o<=0 and marker_cnt_o<=0. clear_i has priority over a simultaneous increment or flag set.
- Reset mid-operation: a held spike or in-flight output is discarded. The first event after reset always gets a marker, including when its time is 0.
- Counter: wraps never; holds at 0xFFFF.

Test Plan:
- Reset, enable_i=1, inputs (t=5,p=A),(t=5,p=B),(t=7,p=C), out_ready_i=1 -> output TIME5, A, B, TIME7, C; marker_cnt_o=2; in_ready_o low exactly in the 2 DATA_PEND cycles.
- First event after reset has t=0 -> TIME0 emitted before the spike; err_backwards_o stays 0.
- Inputs t=9 then t=4 -> TIME9, spike, TIME4, spike; err_backwards_o=1 from the cycle after accepting t=4. Pulse clear_i -> err_backwards_o=0 and marker_cnt_o=0.
- Inputs t=9 then t=0 -> TIME0 emitted; err_backwards_o remains 0.
- out_ready_i low for 3 cycles while TIME3 is presented -> out_data_o=3 and out_is_time_o=1 held stable; no input accepted; the spike follows after out_ready_i rises.
- enable_i=0 with inputs (t=1),(t=2) at back-to-back valid and ready -> 2 spikes on consecutive cycles, no markers. Raise enable_i, send t=2 -> TIME2 is emitted.

Source files
------------

// File: rtl/evt_time_marker.sv
// Spike serializer that inserts a TIME event ahead of the first spike of each new timestamp.
// One-entry registered output stage; a spike that needs a marker waits in a hold register.
module evt_time_marker #(
  parameter int TIME_W    = 16,
  parameter int PAYLOAD_W = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 enable_i,
  input  logic                 clear_i,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [TIME_W-1:0]    in_time_i,
  input  logic [PAYLOAD_W-1:0] in_payload_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic                 out_is_time_o,
  output logic [PAYLOAD_W-1:0] out_data_o,
  output logic                 err_backwards_o,
  output logic [15:0]          marker_cnt_o
);

  if (PAYLOAD_W < TIME_W) begin : g_bad_widths
    $error("PAYLOAD_W must be at least TIME_W");
  end

  typedef enum logic {IDLE, DATA_PEND} state_t;

  state_t               state;
  logic [TIME_W-1:0]    last_time;
  logic                 have_time;
  logic [PAYLOAD_W-1:0] hold_payload;

  logic accept;
  logic need_marker;
  logic backwards;

  // Downstream ready passes straight through so the stage sustains one event per cycle.
  assign in_ready_o  = (state == IDLE) & (~out_valid_o | out_ready_i);
  assign accept      = in_valid_i & in_ready_o;
  assign need_marker = enable_i & (~have_time | (in_time_i != last_time));
  // A zero timestamp is a legal timebase restart, never a backwards step.
  assign backwards   = enable_i & have_time & (in_time_i < last_time) & (in_time_i != '0);

  // NOTE: all state here is sequential, so every assignment is non-blocking (<=);
  // blocking assignments would make update order depend on statement order.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state           <= IDLE;
      out_valid_o     <= 1'b0;
      out_is_time_o   <= 1'b0;
      out_data_o      <= '0;
      hold_payload    <= '0;
      last_time       <= '0;
      have_time       <= 1'b0;
      err_backwards_o <= 1'b0;
      marker_cnt_o    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            out_valid_o <= 1'b1;
            if (need_marker) begin
              out_is_time_o <= 1'b1;
              out_data_o    <= PAYLOAD_W'(in_time_i);
              hold_payload  <= in_payload_i;
              last_time     <= in_time_i;
              state         <= DATA_PEND;
            end else begin
              out_is_time_o <= 1'b0;
              out_data_o    <= in_payload_i;
            end
          end else if (out_ready_i) begin
            out_valid_o <= 1'b0;
          end
        end
        DATA_PEND: begin
          // Completes even if enable_i dropped while the marker was waiting.
          if (out_ready_i) begin
            out_valid_o   <= 1'b1;
            out_is_time_o <= 1'b0;
            out_data_o    <= hold_payload;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase

      // Disabling forgets the timebase so re-enable always starts with a marker.
      if (accept && need_marker) begin
        have_time <= 1'b1;
      end else if (!enable_i) begin
        have_time <= 1'b0;
      end

      if (clear_i) begin
        err_backwards_o <= 1'b0;
        marker_cnt_o    <= '0;
      end else begin
        if (accept && backwards) begin
          err_backwards_o <= 1'b1;
        end
        if (accept && need_marker && (marker_cnt_o != 16'hFFFF)) begin
          marker_cnt_o <= marker_cnt_o + 16'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_evt_time_marker.sv
// Bench for evt_time_marker: table of events with hand-derived marker/error counts, a
// cycle model feeding an output scoreboard, and hand sequences for hold, disable and reset.
module tb_evt_time_marker;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic        clear;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_time;
  logic [15:0] in_payload;
  logic        out_valid;
  logic        out_ready;
  logic        out_is_time;
  logic [15:0] out_data;
  logic        err_backwards;
  logic [15:0] marker_cnt;

  always #5 clk = ~clk;

  evt_time_marker #(.TIME_W(16), .PAYLOAD_W(16)) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .enable_i       (enable),
    .clear_i        (clear),
    .in_valid_i     (in_valid),
    .in_ready_o     (in_ready),
    .in_time_i      (in_time),
    .in_payload_i   (in_payload),
    .out_valid_o    (out_valid),
    .out_ready_i    (out_ready),
    .out_is_time_o  (out_is_time),
    .out_data_o     (out_data),
    .err_backwards_o(err_backwards),
    .marker_cnt_o   (marker_cnt)
  );

  typedef struct {
    logic        is_time;
    logic [15:0] data;
  } item_t;

  typedef struct {
    logic        rst_before;
    logic        clr_before;
    logic [15:0] t;
    logic [15:0] p;
    logic [15:0] exp_cnt;
    logic        exp_err;
  } vec_t;

  item_t sb_q[$];
  int    n_vec  = 0;
  int    n_miss = 0;

  // Reference model state
  logic        m_valid, m_pend, m_have, m_err;
  logic [15:0] m_last, m_cnt;
  int          cyc = 0, last_pop = 0, prev_pop = 0, low_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    sb_q.delete();
    m_valid = 0; m_pend = 0; m_have = 0; m_err = 0; m_last = '0; m_cnt = '0;
    low_cnt = 0;
  endtask

  // Cycle model: checks at the falling edge, then advances to the state after the next rise.
  always @(negedge clk) begin
    if (rst_n) begin
      logic  acc, need;
      item_t it;
      cyc++;
      check("out_valid", out_valid, m_valid);
      check("in_ready", in_ready, !m_pend && (!m_valid || out_ready));
      check("err_backwards", err_backwards, m_err);
      check("marker_cnt", marker_cnt, m_cnt);
      if (!in_ready) low_cnt++;
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          check("unexpected_output", 1, 0);
        end else begin
          it = sb_q.pop_front();
          check("out_is_time", out_is_time, it.is_time);
          check("out_data", out_data, it.data);
        end
        prev_pop = last_pop;
        last_pop = cyc;
      end
      acc  = in_valid && in_ready;
      need = enable && (!m_have || in_time != m_last);
      if (m_pend) begin
        if (out_ready) begin
          m_pend  = 0;
          m_valid = 1;
        end
      end else if (acc) begin
        m_valid = 1;
        if (need) begin
          if (m_have && in_time < m_last && in_time != 0) m_err = 1;
          sb_q.push_back('{1'b1, in_time});
          sb_q.push_back('{1'b0, in_payload});
          m_last = in_time;
          m_pend = 1;
          if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
        end else begin
          sb_q.push_back('{1'b0, in_payload});
        end
      end else if (out_ready) begin
        m_valid = 0;
      end
      if (acc && need) m_have = 1;
      else if (!enable) m_have = 0;
      if (clear) begin
        m_err = 0;
        m_cnt = '0;
      end
    end
  end

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 0; in_valid = 0; clear = 0;
    model_reset();
    @(posedge clk); #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_is_time", out_is_time, 0);
    check("rst_out_data", out_data, 0);
    check("rst_err", err_backwards, 0);
    check("rst_cnt", marker_cnt, 0);
    rst_n = 1;
  endtask

  // Present one event and hold it until accepted; leaves the caller at posedge+1.
  task automatic send(input logic en, input logic [15:0] t, input logic [15:0] p);
    logic acc;
    int   k;
    enable = en; in_valid = 1; in_time = t; in_payload = p;
    k = 0;
    do begin
      @(negedge clk); acc = in_ready;
      @(posedge clk); #1; k++;
    end while (!acc && k < 50);
    if (!acc) check("accept_timeout", 0, 1);
    in_valid = 0;
  endtask

  task automatic drain();
    int k;
    out_ready = 1; in_valid = 0;
    k = 0;
    while ((sb_q.size() != 0 || out_valid) && k < 20) begin
      @(posedge clk); #1; k++;
    end
    check("drain_timeout", k >= 20, 0);
  endtask

  vec_t tbl[8];

  initial begin
    rst_n = 0; enable = 1; clear = 0; in_valid = 0; in_time = '0; in_payload = '0;
    out_ready = 1;
    model_reset();

    tbl[0] = '{1'b1, 1'b0, 16'd5, 16'h00A0, 16'd1, 1'b0};
    tbl[1] = '{1'b0, 1'b0, 16'd5, 16'h00B0, 16'd1, 1'b0};
    tbl[2] = '{1'b0, 1'b0, 16'd7, 16'h00C0, 16'd2, 1'b0};
    tbl[3] = '{1'b1, 1'b0, 16'd0, 16'h00D0, 16'd1, 1'b0};
    tbl[4] = '{1'b1, 1'b0, 16'd9, 16'h0090, 16'd1, 1'b0};
    tbl[5] = '{1'b0, 1'b0, 16'd4, 16'h0040, 16'd2, 1'b1};
    tbl[6] = '{1'b0, 1'b1, 16'd9, 16'h0091, 16'd1, 1'b0};
    tbl[7] = '{1'b0, 1'b0, 16'd0, 16'h0001, 16'd2, 1'b0};

    for (int i = 0; i < 8; i++) begin
      if (tbl[i].rst_before) do_reset();
      if (tbl[i].clr_before) begin
        clear = 1;
        @(posedge clk); #1;
        clear = 0;
        check("clear_err", err_backwards, 0);
        check("clear_cnt", marker_cnt, 0);
      end
      send(1'b1, tbl[i].t, tbl[i].p);
      drain();
      check($sformatf("vec%0d_cnt", i), marker_cnt, tbl[i].exp_cnt);
      check($sformatf("vec%0d_err", i), err_backwards, tbl[i].exp_err);
      if (i == 2) check("data_pend_cycles", low_cnt, 2);
    end

    // Marker held under backpressure; a same-time spike waits behind it.
    out_ready = 0; enable = 1; in_valid = 1; in_time = 16'd3; in_payload = 16'h0033;
    @(posedge clk); #1;
    in_payload = 16'h0034;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("hold_data", out_data, 16'd3);
      check("hold_is_time", out_is_time, 1);
      check("hold_in_ready", in_ready, 0);
      @(posedge clk); #1;
    end
    out_ready = 1;
    send(1'b1, 16'd3, 16'h0034);
    drain();
    check("hold_cnt", marker_cnt, 16'd3);

    // Disabled: pure pass-through on consecutive cycles, then re-enable forces a marker.
    send(1'b0, 16'd1, 16'h0011);
    send(1'b0, 16'd2, 16'h0022);
    drain();
    check("bypass_consecutive", last_pop - prev_pop, 1);
    check("bypass_cnt", marker_cnt, 16'd3);
    send(1'b1, 16'd2, 16'h0023);
    drain();
    check("reenable_cnt", marker_cnt, 16'd4);

    // Reset while a marker is stalled; the next t=0 event still gets a marker.
    out_ready = 0;
    send(1'b1, 16'd8, 16'h0088);
    check("stall_valid", out_valid, 1);
    do_reset();
    out_ready = 1;
    send(1'b1, 16'd0, 16'h0001);
    drain();
    check("post_reset_cnt", marker_cnt, 16'd1);
    check("post_reset_err", err_backwards, 0);
    check("sb_empty", sb_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
